mul_share_arb4: RTL and testbench

MUL_SHARE_ARB4 -- requirements
Module: mul_share_arb4

---
 rtl/mul_share_arb4.sv | 131 +++++++++++++
 tb/tb_mul_share_arb4.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arb4.sv
// ============================================================================
// Module   : mul_share_arb4
// Purpose  : Four requesters share one signed 16x16 multiplier behind an
//            arbiter and a single-entry result buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_tc_16_16 (
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  output logic signed [31:0] product
);
  assign product = a * b;
endmodule

module mul_share_arb4 #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  output logic [3:0]  req_ready,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_id,
  output logic [31:0] rsp_product,
  output logic [15:0] op_count
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_ptr;
  logic [1:0]  r_id;
  logic [31:0] r_product;
  logic [15:0] r_count;

  logic        w_can_accept;
  logic        w_drain;
  logic        w_any;
  logic        w_grant;
  logic [1:0]  w_base;
  logic [7:0]  w_dbl;
  logic [3:0]  w_rot;
  logic [1:0]  w_off;
  logic [1:0]  w_win;
  logic [15:0] w_a;
  logic [15:0] w_b;
  logic [31:0] w_prod;

  // Rotate the request vector so the pointer position lands at bit 0; a plain
  // priority encode then yields the offset from the pointer.
  assign w_base = (RR_EN != 0) ? r_ptr : 2'd0;
  assign w_dbl  = {req_valid, req_valid};
  assign w_rot  = w_dbl[{1'b0, w_base} +: 4];
  assign w_any  = |req_valid;

  always_comb begin
    w_off = 2'd0;
    casez (w_rot)
      4'b???1: w_off = 2'd0;
      4'b??10: w_off = 2'd1;
      4'b?100: w_off = 2'd2;
      4'b1000: w_off = 2'd3;
      default: w_off = 2'd0;
    endcase
  end

  assign w_win        = w_base + w_off;
  assign w_drain      = (r_state == S_FULL) && rsp_ready;
  assign w_can_accept = !rst && ((r_state == S_EMPTY) || rsp_ready);
  assign w_grant      = w_can_accept && w_any;
  assign req_ready    = w_grant ? (4'b0001 << w_win) : 4'b0000;

  assign w_a = req_a[{w_win, 4'b0000} +: 16];
  assign w_b = req_b[{w_win, 4'b0000} +: 16];

  mul_tc_16_16 u_mul (
    .a       (w_a),
    .b       (w_b),
    .product (w_prod)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_grant) begin
      w_state_nxt = S_FULL;
    end else if (w_drain) begin
      w_state_nxt = S_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_EMPTY;
      r_ptr     <= 2'd0;
      r_id      <= 2'd0;
      r_product <= 32'd0;
      r_count   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_id      <= w_win;
        r_product <= w_prod;
        if (RR_EN != 0) begin
          r_ptr <= w_win + 2'd1;
        end
      end
      if (w_drain && (r_count != C_CNT_MAX)) begin
        r_count <= r_count + 16'd1;
      end
    end
  end

  assign rsp_valid   = (r_state == S_FULL);
  assign rsp_id      = r_id;
  assign rsp_product = r_product;
  assign op_count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arb4.sv
// ============================================================================
// Module   : tb_mul_share_arb4
// Purpose  : Random and directed traffic on a round-robin and a fixed-priority
//            instance, compared each cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_share_arb4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_ready;

  logic [3:0]  rdy   [2];
  logic        vld   [2];
  logic [1:0]  id    [2];
  logic [31:0] prod  [2];
  logic [15:0] cnt   [2];

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  // model state, index 0 = round robin, 1 = fixed priority
  bit          m_full [2];
  int          m_ptr  [2];
  int          m_id   [2];
  logic [31:0] m_prod [2];
  int          m_cnt  [2];
  logic [3:0]  snap   [2];

  mul_share_arb4 #(.RR_EN(1)) u_rr (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(vld[0]), .rsp_ready(rsp_ready),
    .rsp_id(id[0]), .rsp_product(prod[0]), .op_count(cnt[0])
  );

  mul_share_arb4 #(.RR_EN(0)) u_fp (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_a(req_a), .req_b(req_b), .rsp_valid(vld[1]), .rsp_ready(rsp_ready),
    .rsp_id(id[1]), .rsp_product(prod[1]), .op_count(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int winner(int d);
    int base;
    base = (d == 0) ? m_ptr[0] : 0;
    for (int k = 0; k < 4; k++) begin
      if (req_valid[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int d);
    int w;
    if (rst) return 4'b0000;
    if (m_full[d] && !rsp_ready) return 4'b0000;
    w = winner(d);
    if (w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  // One clock: check outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    logic [3:0] g [2];
    #3;
    for (int d = 0; d < 2; d++) begin
      g[d]    = exp_ready(d);
      snap[d] = rdy[d];
      chk(d == 0 ? "rr_ready" : "fp_ready", 32'(rdy[d]), 32'(g[d]));
      chk(d == 0 ? "rr_valid" : "fp_valid", 32'(vld[d]), 32'(m_full[d]));
      if (m_full[d]) begin
        chk(d == 0 ? "rr_id" : "fp_id", 32'(id[d]), 32'(m_id[d]));
        chk(d == 0 ? "rr_prod" : "fp_prod", prod[d], m_prod[d]);
      end
      chk(d == 0 ? "rr_count" : "fp_count", 32'(cnt[d]), 32'(m_cnt[d]));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_full[d] = 0; m_ptr[d] = 0; m_id[d] = 0; m_prod[d] = 0; m_cnt[d] = 0;
      end else begin
        int w;
        bit drain;
        drain = m_full[d] && rsp_ready;
        if (drain && m_cnt[d] < 65535) m_cnt[d]++;
        if (g[d] != 4'b0000) begin
          int sa, sb;
          w = winner(d);
          sa = int'($signed(req_a[16*w +: 16]));
          sb = int'($signed(req_b[16*w +: 16]));
          m_full[d] = 1;
          m_id[d]   = w;
          m_prod[d] = 32'(sa * sb);
          if (d == 0) begin
            m_ptr[0] = (w + 1) % 4;
            n_acc++;
          end
        end else if (drain) begin
          m_full[d] = 0;
        end
      end
    end
    #1;
  endtask

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic rand_operands();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = rand_op();
      req_b[16*i +: 16] = rand_op();
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    for (int d = 0; d < 2; d++) begin
      m_full[d] = 0; m_ptr[d] = 0; m_id[d] = 0; m_prod[d] = 0; m_cnt[d] = 0;
    end
    @(posedge clk); #1;

    // reset held two cycles with every requester valid
    cycle();
    chk("reset_ready", 32'(snap[0]), 32'h0);
    cycle();
    chk("reset_valid", 32'(vld[0]), 32'h0);
    chk("reset_count", 32'(cnt[0]), 32'h0);

    // single request from requester 2, most negative operands
    rst = 1'b0; req_valid = 4'b0100; rsp_ready = 1'b1;
    req_a[47:32] = 16'h8000; req_b[47:32] = 16'h8000;
    cycle();
    req_valid = 4'b0000;
    chk("single_valid", 32'(vld[0]), 32'h1);
    chk("single_id", 32'(id[0]), 32'h2);
    chk("single_prod", prod[0], 32'h4000_0000);
    cycle();
    chk("single_count", 32'(cnt[0]), 32'h1);

    // round robin from a fresh pointer
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 4'hF; rsp_ready = 1'b1;
    begin
      logic [3:0] exp_seq [5];
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int c = 0; c < 5; c++) begin
        rand_operands();
        cycle();
        chk("rr_seq", 32'(snap[0]), 32'(exp_seq[c]));
        chk("rr_full", 32'(vld[0]), 32'h1);
      end
    end

    // backpressure: full with downstream stalled
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rand_operands();
      cycle();
      chk("bp_ready", 32'(snap[0]), 32'h0);
    end
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release", 32'(snap[0] != 4'b0000), 32'h1);

    // fixed priority with requesters 1 and 3 competing
    req_valid = 4'b1010;
    for (int c = 0; c < 6; c++) begin
      rand_operands();
      cycle();
      chk("fp_grant1", 32'(snap[1]), 32'b0010);
    end

    // mid-stream reset while full
    req_valid = 4'hF; rst = 1'b1;
    cycle();
    chk("mid_rst_valid", 32'(vld[0]), 32'h0);
    chk("mid_rst_count", 32'(cnt[0]), 32'h0);
    rst = 1'b0;
    cycle();
    chk("mid_rst_first", 32'(snap[0]), 32'b0001);

    // random traffic
    for (int c = 0; c < 4000 && n_acc < 1300; c++) begin
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rand_operands();
      cycle();
    end
    chk("enough_txns", 32'(n_acc >= 1000), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
